// File: rtl/i2c_cmd_sequencer_pkg.sv
// ============================================================================
// Module   : i2c_cmd_sequencer_pkg
// Purpose  : Shared states, command markers and field helpers for the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_cmd_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_DELAY,
    ST_LAUNCH,
    ST_WAIT_END,
    ST_CHECK,
    ST_ADVANCE
  } state_e;

  localparam logic [7:0] CMD_END   = 8'hFF;
  localparam logic [7:0] CMD_DELAY = 8'hFE;

  // Command word layout: {dev[23:16], reg[15:8], val[7:0]}; delay count in [15:0]
  function automatic logic [7:0] cmd_dev(input logic [23:0] word);
    return word[23:16];
  endfunction

  function automatic logic [15:0] cmd_arg(input logic [23:0] word);
    return word[15:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_cmd_sequencer_if.sv
// ============================================================================
// Module   : i2c_cmd_sequencer_if
// Purpose  : Table, host and I2C-controller signals of the command sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface i2c_cmd_sequencer_if #(
  parameter int TBL_AW = 8
);
  logic              GO;
  logic [TBL_AW-1:0] TBL_ADDR;
  logic [23:0]       TBL_DATA;
  logic              HOST_REQ;
  logic [23:0]       HOST_DATA;
  logic              HOST_BUSY;
  logic              HOST_DONE;
  logic              HOST_ERR;
  logic              INIT_DONE;
  logic              INIT_ERR;
  logic [7:0]        ERR_COUNT;
  logic              I2C_START;
  logic [23:0]       I2C_DATA;
  logic              I2C_END;
  logic              I2C_ACK;

  modport master (
    input  GO, TBL_DATA, HOST_REQ, HOST_DATA, I2C_END, I2C_ACK,
    output TBL_ADDR, HOST_BUSY, HOST_DONE, HOST_ERR,
           INIT_DONE, INIT_ERR, ERR_COUNT, I2C_START, I2C_DATA
  );

  modport slave (
    output GO, TBL_DATA, HOST_REQ, HOST_DATA, I2C_END, I2C_ACK,
    input  TBL_ADDR, HOST_BUSY, HOST_DONE, HOST_ERR,
           INIT_DONE, INIT_ERR, ERR_COUNT, I2C_START, I2C_DATA
  );
endinterface

`default_nettype wire

// File: rtl/i2c_delay_timer.sv
// ============================================================================
// Module   : i2c_delay_timer
// Purpose  : Counts a loaded number of units, each DELAY_DIV clock cycles long.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_delay_timer #(
  parameter int DELAY_DIV = 50000
) (
  input  wire logic        CLK,
  input  wire logic        RESET,
  input  wire logic        load_i,
  input  wire logic [15:0] units_i,
  output logic             done_o
);

  localparam int             c_PW       = (DELAY_DIV > 1) ? $clog2(DELAY_DIV) : 1;
  localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(DELAY_DIV - 1);

  logic [c_PW-1:0] pre_q;
  logic [15:0]     units_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pre_q   <= '0;
      units_q <= '0;
    end else if (load_i) begin
      pre_q   <= '0;
      units_q <= units_i;
    end else if (units_q != 16'd0) begin
      if (pre_q == c_PRE_LAST) begin
        pre_q   <= '0;
        units_q <= units_q - 16'd1;
      end else begin
        pre_q <= pre_q + c_PW'(1);
      end
    end
  end

  // A zero-unit load reports done on the very next cycle
  assign done_o = (units_q == 16'd0) && !load_i;

endmodule

`default_nettype wire

// File: rtl/i2c_cmd_sequencer.sv
// ============================================================================
// Module   : i2c_cmd_sequencer
// Purpose  : Plays a ROM command table into an I2C byte controller, then serves a host.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_cmd_sequencer
  import i2c_cmd_sequencer_pkg::*;
#(
  parameter int TBL_AW        = 8,
  parameter int RETRIES       = 2,
  parameter int DELAY_DIV     = 50000,
  parameter int START_TIMEOUT = 16
) (
  input wire logic             CLK,
  input wire logic             RESET,
  i2c_cmd_sequencer_if.master  bus
);

  localparam int              c_TW       = $clog2(START_TIMEOUT + 1);
  localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(START_TIMEOUT - 1);
  localparam logic [7:0]      c_RETRIES  = 8'(RETRIES);

  state_e            state_q, state_d;
  logic [TBL_AW-1:0] addr_q, addr_d;
  logic [23:0]       data_q, data_d;
  logic              start_q, start_d;
  logic              host_busy_q, host_busy_d;
  logic              host_done_q, host_done_d;
  logic              host_err_q, host_err_d;
  logic              init_done_q, init_done_d;
  logic              init_err_q, init_err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [7:0]        retry_q, retry_d;
  logic [c_TW-1:0]   tmo_q, tmo_d;
  logic              src_host_q, src_host_d;
  logic              w_tmr_load, w_tmr_done;
  logic              w_xfer_end, w_xfer_fail;

  i2c_delay_timer #(
    .DELAY_DIV (DELAY_DIV)
  ) u_delay (
    .CLK     (CLK),
    .RESET   (RESET),
    .load_i  (w_tmr_load),
    .units_i (cmd_arg(bus.TBL_DATA)),
    .done_o  (w_tmr_done)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      start_q     <= 1'b0;
      host_busy_q <= 1'b0;
      host_done_q <= 1'b0;
      host_err_q  <= 1'b0;
      init_done_q <= 1'b0;
      init_err_q  <= 1'b0;
      err_cnt_q   <= '0;
      retry_q     <= '0;
      tmo_q       <= '0;
      src_host_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      start_q     <= start_d;
      host_busy_q <= host_busy_d;
      host_done_q <= host_done_d;
      host_err_q  <= host_err_d;
      init_done_q <= init_done_d;
      init_err_q  <= init_err_d;
      err_cnt_q   <= err_cnt_d;
      retry_q     <= retry_d;
      tmo_q       <= tmo_d;
      src_host_q  <= src_host_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    start_d     = start_q;
    host_busy_d = host_busy_q;
    host_done_d = 1'b0;
    host_err_d  = host_err_q;
    init_done_d = init_done_q;
    init_err_d  = init_err_q;
    err_cnt_d   = err_cnt_q;
    retry_d     = retry_q;
    tmo_d       = tmo_q;
    src_host_d  = src_host_q;
    w_tmr_load  = 1'b0;
    w_xfer_end  = 1'b0;
    w_xfer_fail = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Waiting for I2C_END keeps us off a controller still busy from before reset
        if (bus.I2C_END) begin
          if (bus.GO) begin
            init_done_d = 1'b0;
            init_err_d  = 1'b0;
            err_cnt_d   = '0;
            addr_d      = '0;
            src_host_d  = 1'b0;
            state_d     = ST_FETCH;
          end else if (bus.HOST_REQ) begin
            data_d      = bus.HOST_DATA;
            host_busy_d = 1'b1;
            src_host_d  = 1'b1;
            retry_d     = '0;
            tmo_d       = '0;
            start_d     = 1'b1;
            state_d     = ST_LAUNCH;
          end
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        if (cmd_dev(bus.TBL_DATA) == CMD_END) begin
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (cmd_dev(bus.TBL_DATA) == CMD_DELAY) begin
          w_tmr_load = 1'b1;
          state_d    = ST_DELAY;
        end else begin
          data_d  = bus.TBL_DATA;
          retry_d = '0;
          tmo_d   = '0;
          start_d = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_DELAY: if (w_tmr_done) state_d = ST_ADVANCE;
      ST_LAUNCH: begin
        if (!bus.I2C_END) begin
          start_d = 1'b0;
          state_d = ST_WAIT_END;
        end else if (tmo_q == c_TMO_LAST) begin
          start_d     = 1'b0;
          w_xfer_end  = 1'b1;
          w_xfer_fail = 1'b1;
        end else begin
          tmo_d = tmo_q + c_TW'(1);
        end
      end
      ST_WAIT_END: if (bus.I2C_END) state_d = ST_CHECK;
      ST_CHECK: begin
        if (!bus.I2C_ACK) begin
          w_xfer_end = 1'b1;
        end else if (retry_q < c_RETRIES) begin
          retry_d = retry_q + 8'd1;
          tmo_d   = '0;
          start_d = 1'b1;
          state_d = ST_LAUNCH;
        end else begin
          w_xfer_end  = 1'b1;
          w_xfer_fail = 1'b1;
        end
      end
      ST_ADVANCE: begin
        if (addr_q == '1) begin
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          addr_d  = addr_q + TBL_AW'(1);
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_xfer_end) begin
      if (src_host_q) begin
        host_done_d = 1'b1;
        host_err_d  = w_xfer_fail;
        host_busy_d = 1'b0;
        state_d     = ST_IDLE;
      end else begin
        if (w_xfer_fail) begin
          init_err_d = 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
        state_d = ST_ADVANCE;
      end
    end
  end

  assign bus.TBL_ADDR  = addr_q;
  assign bus.I2C_START = start_q;
  assign bus.I2C_DATA  = data_q;
  assign bus.HOST_BUSY = host_busy_q;
  assign bus.HOST_DONE = host_done_q;
  assign bus.HOST_ERR  = host_err_q;
  assign bus.INIT_DONE = init_done_q;
  assign bus.INIT_ERR  = init_err_q;
  assign bus.ERR_COUNT = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_cmd_sequencer.sv
// ============================================================================
// Module   : tb_i2c_cmd_sequencer
// Purpose  : Directed bench with a ROM model and a reactive I2C controller model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_cmd_sequencer;

  localparam int TBL_AW = 4;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  i2c_cmd_sequencer_if #(.TBL_AW(TBL_AW)) bus ();

  i2c_cmd_sequencer #(
    .TBL_AW        (TBL_AW),
    .RETRIES       (2),
    .DELAY_DIV     (10),
    .START_TIMEOUT (16)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int chk_total = 0;
  int chk_pass  = 0;

  logic [23:0] rom [0:(1<<TBL_AW)-1];
  always @(posedge CLK) bus.TBL_DATA <= rom[bus.TBL_ADDR];

  // Controller model: accepts a START rise while idle, busy 3 cycles (longer while hold=1).
  // 0x720835 is always NACKed; 0x55AA01 is never accepted, forcing a start timeout.
  int          cyc = 0;
  int          busy_left = 0;
  int          end_rise_cyc = 0;
  int          gap_delay = -1;
  int          tmo_hi = 0;
  int          nack_starts = 0;
  int          host_done_cnt = 0;
  int          bad_busy = 0;
  logic        host_err_seen = 1'b0;
  logic        hold = 1'b0;
  logic        start_prev = 1'b0;
  logic [23:0] log_q [$];

  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (bus.HOST_DONE) begin
      host_done_cnt = host_done_cnt + 1;
      host_err_seen = bus.HOST_ERR;
    end
    if (bus.HOST_BUSY && !bus.INIT_DONE) bad_busy = bad_busy + 1;
    if (bus.I2C_START && bus.I2C_DATA == 24'h55AA01) tmo_hi = tmo_hi + 1;
    if (busy_left > 0) begin
      if (!hold) busy_left = busy_left - 1;
      if (busy_left == 0) begin
        bus.I2C_END  = 1'b1;
        end_rise_cyc = cyc;
      end
    end else if (RESET) begin
      bus.I2C_END = 1'b1;
      bus.I2C_ACK = 1'b0;
    end else if (bus.I2C_START && !start_prev && bus.I2C_DATA != 24'h55AA01) begin
      if (bus.I2C_DATA == 24'h341111) gap_delay = cyc - end_rise_cyc;
      if (bus.I2C_DATA == 24'h720835) nack_starts = nack_starts + 1;
      log_q.push_back(bus.I2C_DATA);
      bus.I2C_END = 1'b0;
      bus.I2C_ACK = (bus.I2C_DATA == 24'h720835);
      busy_left   = 3;
    end
    start_prev = bus.I2C_START;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_total = chk_total + 1;
    if (obs === exp) chk_pass = chk_pass + 1;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic go_pulse();
    @(negedge CLK);
    bus.GO = 1'b1;
    @(negedge CLK);
    bus.GO = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!bus.INIT_DONE && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.INIT_DONE) check({tag, "_init_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic host_handshake(input string tag);
    int n = 0;
    while (!bus.HOST_BUSY && host_done_cnt == 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    bus.HOST_REQ = 1'b0;
    n = 0;
    while (host_done_cnt == 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (host_done_cnt == 0) check({tag, "_host_timeout"}, 32'd0, 32'd1);
    tick(2);
  endtask

  task automatic clear_model();
    log_q.delete();
    nack_starts   = 0;
    host_done_cnt = 0;
    bad_busy      = 0;
    tmo_hi        = 0;
    gap_delay     = -1;
  endtask

  task automatic fill_rom(input logic [23:0] fill);
    for (int i = 0; i < (1 << TBL_AW); i++) rom[i] = fill;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got hang, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RESET         = 1'b1;
    bus.GO        = 1'b0;
    bus.HOST_REQ  = 1'b0;
    bus.HOST_DATA = '0;
    fill_rom(24'hFF0000);
    tick(3);
    check("rst_start",     32'(bus.I2C_START), 32'd0);
    check("rst_init_done", 32'(bus.INIT_DONE), 32'd0);
    RESET = 1'b0;
    tick(2);
    check("rst_addr",      32'(bus.TBL_ADDR),  32'd0);
    check("rst_data",      32'(bus.I2C_DATA),  32'd0);
    check("rst_host_busy", 32'(bus.HOST_BUSY), 32'd0);
    check("rst_err_count", 32'(bus.ERR_COUNT), 32'd0);

    // Two plain writes then end marker
    rom[0] = 24'h341E00; rom[1] = 24'h340017; rom[2] = 24'hFF0000;
    clear_model();
    go_pulse();
    wait_init("a");
    tick(2);
    check("a_writes",    32'(log_q.size()), 32'd2);
    check("a_entry0",    32'(log_q[0]),     32'h341E00);
    check("a_entry1",    32'(log_q[1]),     32'h340017);
    check("a_init_done", 32'(bus.INIT_DONE), 32'd1);
    check("a_init_err",  32'(bus.INIT_ERR),  32'd0);
    check("a_err_count", 32'(bus.ERR_COUNT), 32'd0);

    // NACK retries, delay, start timeout, host request held off mid-init
    fill_rom(24'hFF0000);
    rom[0] = 24'h341E00; rom[1] = 24'h720835; rom[2] = 24'h340017;
    rom[3] = 24'hFE0003; rom[4] = 24'h341111; rom[5] = 24'h55AA01;
    clear_model();
    go_pulse();
    tick(8);
    bus.HOST_DATA = 24'h347904;
    bus.HOST_REQ  = 1'b1;
    wait_init("b");
    host_handshake("b");
    check("b_nack_starts", 32'(nack_starts), 32'd3);
    check("b_writes",      32'(log_q.size()), 32'd7);
    check("b_after_nack",  32'(log_q[4]), 32'h340017);
    check("b_after_delay", 32'(log_q[5]), 32'h341111);
    // 30 delay cycles plus CHECK/ADVANCE/FETCH/DECODE/DELAY-entry/ADVANCE/FETCH/DECODE/LAUNCH
    check("b_delay_gap",   32'(gap_delay), 32'd39);
    check("b_tmo_start_hi", 32'(tmo_hi), 32'd16);
    check("b_err_count",   32'(bus.ERR_COUNT), 32'd2);
    check("b_init_err",    32'(bus.INIT_ERR), 32'd1);
    check("b_host_early",  32'(bad_busy), 32'd0);
    check("b_host_data",   32'(log_q[6]), 32'h347904);
    check("b_host_done",   32'(host_done_cnt), 32'd1);
    check("b_host_err",    32'(host_err_seen), 32'd0);
    check("b_host_busy",   32'(bus.HOST_BUSY), 32'd0);

    // GO and HOST_REQ together: init wins
    fill_rom(24'hFF0000);
    rom[0] = 24'h341E00; rom[1] = 24'h340017;
    clear_model();
    @(negedge CLK);
    bus.GO        = 1'b1;
    bus.HOST_REQ  = 1'b1;
    bus.HOST_DATA = 24'h347904;
    @(negedge CLK);
    bus.GO = 1'b0;
    check("c_host_busy_start", 32'(bus.HOST_BUSY), 32'd0);
    wait_init("c");
    host_handshake("c");
    check("c_host_early", 32'(bad_busy), 32'd0);
    check("c_writes",     32'(log_q.size()), 32'd3);
    check("c_host_last",  32'(log_q[2]), 32'h347904);
    check("c_err_count",  32'(bus.ERR_COUNT), 32'd0);

    // Table without end marker stops at the last address
    fill_rom(24'hFE0000);
    clear_model();
    go_pulse();
    wait_init("e");
    tick(3);
    check("e_last_addr", 32'(bus.TBL_ADDR), 32'd15);
    check("e_init_err",  32'(bus.INIT_ERR), 32'd0);
    check("e_no_writes", 32'(log_q.size()), 32'd0);

    // Reset while the controller is mid-transfer
    fill_rom(24'hFF0000);
    rom[0] = 24'h341E00;
    clear_model();
    hold = 1'b1;
    go_pulse();
    n = 0;
    while (log_q.size() == 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    tick(3);
    #2 RESET = 1'b1;
    #1;
    check("d_rst_start", 32'(bus.I2C_START), 32'd0);
    check("d_rst_data",  32'(bus.I2C_DATA),  32'd0);
    check("d_rst_addr",  32'(bus.TBL_ADDR),  32'd0);
    @(negedge CLK);
    RESET  = 1'b0;
    bus.GO = 1'b1;
    tick(10);
    check("d_no_start_busy", 32'(log_q.size()), 32'd1);
    check("d_start_low",     32'(bus.I2C_START), 32'd0);
    hold = 1'b0;
    tick(6);
    bus.GO = 1'b0;
    wait_init("d");
    tick(2);
    check("d_writes",   32'(log_q.size()), 32'd2);
    check("d_relaunch", 32'(log_q[1]), 32'h341E00);

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule

`default_nettype wire
